// File: rtl/jts16_pkg.sv
// Shared definitions for the System 16 work-RAM/VRAM slot arbiter:
// FSM states, grant-owner encoding and SDRAM byte-mask constants.
package jts16_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_CPU,
        GNT_MCU,
        GAP
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_MCU
    } owner_t;

    localparam logic [1:0] DSN_RD = 2'b11;

    // The 68000 is big-endian, so an odd byte address is the low byte (LDSn active).
    function automatic logic [1:0] mcu_dsn(input logic we, input logic lsb);
        if (!we) return DSN_RD;
        return lsb ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/jts16_ramarb_if.sv
// Bus bundle for jts16_ramarb: CPU bus, MCU port and SDRAM request side.
// The slave modport is the arbiter; the master modport is everything around it.
interface jts16_ramarb_if #(parameter int AW = 15);

    logic          cpu_ram_cs;
    logic          cpu_vram_cs;
    logic [AW:1]   cpu_addr;
    logic [15:0]   cpu_dout;
    logic          UDSWn;
    logic          LDSWn;
    logic          cpu_ok;
    logic [15:0]   cpu_data;

    logic          mcu_cs;
    logic          mcu_we;
    logic [AW:0]   mcu_addr;
    logic [7:0]    mcu_din;
    logic          mcu_ok;
    logic [7:0]    mcu_dout;

    logic          ram_cs;
    logic          vram_cs;
    logic [AW:1]   ram_addr;
    logic [15:0]   ram_din;
    logic [1:0]    ram_dsn;
    logic          ram_we;
    logic [15:0]   ram_data;
    logic          ram_ok;

    logic          timeout;

    modport slave (
        input  cpu_ram_cs, cpu_vram_cs, cpu_addr, cpu_dout, UDSWn, LDSWn,
        output cpu_ok, cpu_data,
        input  mcu_cs, mcu_we, mcu_addr, mcu_din,
        output mcu_ok, mcu_dout,
        output ram_cs, vram_cs, ram_addr, ram_din, ram_dsn, ram_we,
        input  ram_data, ram_ok,
        output timeout
    );

    modport master (
        output cpu_ram_cs, cpu_vram_cs, cpu_addr, cpu_dout, UDSWn, LDSWn,
        input  cpu_ok, cpu_data,
        output mcu_cs, mcu_we, mcu_addr, mcu_din,
        input  mcu_ok, mcu_dout,
        input  ram_cs, vram_cs, ram_addr, ram_din, ram_dsn, ram_we,
        output ram_data, ram_ok,
        input  timeout
    );

endinterface

// File: rtl/jts16_ramarb.sv
// Arbitrates the shared work-RAM/VRAM SDRAM slot between the 68000 and the i8751 MCU,
// with round-robin on ties, a forced idle cycle between grants and a grant timeout.
module jts16_ramarb
    import jts16_pkg::*;
#(
    parameter int TOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    jts16_ramarb_if.slave   bus
);

    localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);

    state_t      state;
    owner_t      last_gnt;
    logic        cpu_done;
    logic        first;
    logic        abandon;
    logic        mcu_lsb;
    logic [7:0]  cnt;

    logic        cpu_any;
    logic        cpu_req;
    logic        mcu_req;
    logic        ok_q;
    logic        tout_hit;
    logic [15:0] rd_data;

    assign cpu_any  = bus.cpu_ram_cs | bus.cpu_vram_cs;
    assign cpu_req  = cpu_any & ~cpu_done;
    assign mcu_req  = bus.mcu_cs;
    assign ok_q     = bus.ram_ok & ~first;
    assign tout_hit = (cnt == TOUT_LAST);
    assign rd_data  = ok_q ? bus.ram_data : 16'hffff;

    // The first cycle of every grant ignores ram_ok, since it may still belong to the
    // previous access; an aborted grant answers with all-ones data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_gnt     <= OWN_MCU;
            cpu_done     <= 1'b0;
            first        <= 1'b1;
            abandon      <= 1'b0;
            mcu_lsb      <= 1'b0;
            cnt          <= 8'd0;
            bus.cpu_ok   <= 1'b0;
            bus.cpu_data <= 16'hffff;
            bus.mcu_ok   <= 1'b0;
            bus.mcu_dout <= 8'd0;
            bus.ram_cs   <= 1'b0;
            bus.vram_cs  <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_din  <= 16'd0;
            bus.ram_dsn  <= DSN_RD;
            bus.ram_we   <= 1'b0;
            bus.timeout  <= 1'b0;
        end else begin
            bus.mcu_ok <= 1'b0;
            if (!cpu_any) begin
                bus.cpu_ok <= 1'b0;
                cpu_done   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cnt     <= 8'd0;
                    first   <= 1'b1;
                    abandon <= 1'b0;
                    if (cpu_req && (!mcu_req || last_gnt == OWN_MCU)) begin
                        state        <= GNT_CPU;
                        last_gnt     <= OWN_CPU;
                        bus.ram_cs   <= bus.cpu_ram_cs;
                        bus.vram_cs  <= ~bus.cpu_ram_cs;
                        bus.ram_addr <= bus.cpu_addr;
                        bus.ram_din  <= bus.cpu_dout;
                        bus.ram_dsn  <= {bus.UDSWn, bus.LDSWn};
                        bus.ram_we   <= ~(bus.UDSWn & bus.LDSWn);
                    end else if (mcu_req) begin
                        state        <= GNT_MCU;
                        last_gnt     <= OWN_MCU;
                        bus.ram_cs   <= 1'b1;
                        bus.vram_cs  <= 1'b0;
                        bus.ram_addr <= bus.mcu_addr[$bits(bus.mcu_addr)-1:1];
                        bus.ram_din  <= {bus.mcu_din, bus.mcu_din};
                        bus.ram_dsn  <= mcu_dsn(bus.mcu_we, bus.mcu_addr[0]);
                        bus.ram_we   <= bus.mcu_we;
                        mcu_lsb      <= bus.mcu_addr[0];
                    end
                end
                GNT_CPU, GNT_MCU: begin
                    first <= 1'b0;
                    if (state == GNT_CPU && !cpu_any) abandon <= 1'b1;
                    if (ok_q || tout_hit) begin
                        state       <= GAP;
                        bus.ram_cs  <= 1'b0;
                        bus.vram_cs <= 1'b0;
                        bus.ram_we  <= 1'b0;
                        bus.ram_dsn <= DSN_RD;
                        if (!ok_q) bus.timeout <= 1'b1;
                        if (state == GNT_CPU) begin
                            // A 68k cycle that was withdrawn mid-access gets no answer.
                            if (!abandon && cpu_any) begin
                                bus.cpu_ok   <= 1'b1;
                                cpu_done     <= 1'b1;
                                bus.cpu_data <= rd_data;
                            end
                        end else begin
                            bus.mcu_ok   <= 1'b1;
                            bus.mcu_dout <= mcu_lsb ? rd_data[7:0] : rd_data[15:8];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jts16_ramarb.sv
// Directed self-checking bench for jts16_ramarb: CPU/MCU accesses, tie alternation,
// held chip selects, timeout abort and mid-grant reset.
module tb_jts16_ramarb;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   n;

    jts16_ramarb_if #(.AW(15)) bus();

    jts16_ramarb #(.TOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.cpu_ram_cs  = 1'b0;
        bus.cpu_vram_cs = 1'b0;
        bus.cpu_addr    = 15'd0;
        bus.cpu_dout    = 16'd0;
        bus.UDSWn       = 1'b1;
        bus.LDSWn       = 1'b1;
        bus.mcu_cs      = 1'b0;
        bus.mcu_we      = 1'b0;
        bus.mcu_addr    = 16'd0;
        bus.mcu_din     = 8'd0;
        bus.ram_data    = 16'd0;
        bus.ram_ok      = 1'b0;

        // Reset values
        tick();
        tick();
        check_output("rst_ram_cs",   32'(bus.ram_cs),   0);
        check_output("rst_vram_cs",  32'(bus.vram_cs),  0);
        check_output("rst_dsn",      32'(bus.ram_dsn),  3);
        check_output("rst_cpu_data", 32'(bus.cpu_data), 32'hffff);
        check_output("rst_cpu_ok",   32'(bus.cpu_ok),   0);
        check_output("rst_timeout",  32'(bus.timeout),  0);
        rst = 1'b0;
        tick();

        // 1: CPU read, ram_ok arrives 3 clocks after ram_cs
        $display("[TB] test 1: CPU read");
        bus.cpu_ram_cs = 1'b1;
        bus.cpu_addr   = 15'h1234;
        tick();
        check_output("t1_ram_cs",   32'(bus.ram_cs),   1);
        check_output("t1_addr",     32'(bus.ram_addr), 32'h1234);
        check_output("t1_dsn",      32'(bus.ram_dsn),  3);
        check_output("t1_we",       32'(bus.ram_we),   0);
        tick();
        tick();
        bus.ram_ok   = 1'b1;
        bus.ram_data = 16'hbeef;
        check_output("t1_ok_early", 32'(bus.cpu_ok),   0);
        tick();
        bus.ram_ok = 1'b0;
        check_output("t1_cpu_ok",   32'(bus.cpu_ok),   1);
        check_output("t1_cpu_data", 32'(bus.cpu_data), 32'hbeef);
        check_output("t1_cs_drop",  32'(bus.ram_cs),   0);
        tick();
        tick();
        check_output("t1_ok_held",  32'(bus.cpu_ok),   1);
        check_output("t1_no_regnt", 32'(bus.ram_cs),   0);
        bus.cpu_ram_cs = 1'b0;
        tick();
        check_output("t1_ok_clr",   32'(bus.cpu_ok),   0);

        // 2: MCU write with a stale ram_ok present in the first grant cycle
        $display("[TB] test 2: MCU write");
        bus.mcu_cs   = 1'b1;
        bus.mcu_we   = 1'b1;
        bus.mcu_addr = 16'h0011;
        bus.mcu_din  = 8'ha5;
        bus.ram_ok   = 1'b1;
        tick();
        check_output("t2_ram_cs",  32'(bus.ram_cs),   1);
        check_output("t2_vram_cs", 32'(bus.vram_cs),  0);
        check_output("t2_addr",    32'(bus.ram_addr), 32'h0008);
        check_output("t2_dsn",     32'(bus.ram_dsn),  2);
        check_output("t2_din",     32'(bus.ram_din),  32'ha5a5);
        check_output("t2_we",      32'(bus.ram_we),   1);
        tick();
        check_output("t2_stale",   32'(bus.mcu_ok),   0);
        tick();
        check_output("t2_mcu_ok",  32'(bus.mcu_ok),   1);
        check_output("t2_cs_drop", 32'(bus.ram_cs),   0);
        bus.mcu_cs = 1'b0;
        bus.ram_ok = 1'b0;
        tick();
        check_output("t2_pulse",   32'(bus.mcu_ok),   0);
        check_output("t2_vram",    32'(bus.vram_cs),  0);

        // 3: ties after reset alternate CPU/MCU
        $display("[TB] test 3: tie arbitration");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.cpu_ram_cs = 1'b1;
        bus.cpu_addr   = 15'h0100;
        bus.mcu_cs     = 1'b1;
        bus.mcu_we     = 1'b0;
        bus.mcu_addr   = 16'h0021;
        bus.ram_ok     = 1'b1;
        bus.ram_data   = 16'h1357;
        tick();
        check_output("t3_cpu_first", 32'(bus.ram_addr), 32'h0100);
        tick();
        tick();
        check_output("t3_cpu_ok",    32'(bus.cpu_ok),   1);
        check_output("t3_cpu_data",  32'(bus.cpu_data), 32'h1357);
        tick();
        check_output("t3_gap",       32'(bus.ram_cs),   0);
        tick();
        check_output("t3_mcu_cs",    32'(bus.ram_cs),   1);
        check_output("t3_mcu_addr",  32'(bus.ram_addr), 32'h0010);
        check_output("t3_mcu_dsn",   32'(bus.ram_dsn),  3);
        bus.ram_data = 16'h2468;
        tick();
        tick();
        check_output("t3_mcu_ok",    32'(bus.mcu_ok),   1);
        check_output("t3_mcu_dout",  32'(bus.mcu_dout), 32'h68);
        bus.mcu_cs     = 1'b0;
        bus.cpu_ram_cs = 1'b0;
        tick();
        check_output("t3_dout_held", 32'(bus.mcu_dout), 32'h68);
        bus.cpu_ram_cs = 1'b1;
        bus.cpu_addr   = 15'h0200;
        bus.mcu_cs     = 1'b1;
        bus.mcu_addr   = 16'h0040;
        tick();
        check_output("t3_tie2_cpu",  32'(bus.ram_addr), 32'h0200);
        tick();
        tick();
        bus.cpu_ram_cs = 1'b0;
        tick();
        bus.cpu_ram_cs = 1'b1;
        tick();
        check_output("t3_tie3_mcu",  32'(bus.ram_addr), 32'h0020);
        tick();
        tick();
        check_output("t3_tie3_ok",   32'(bus.mcu_ok),   1);
        bus.mcu_cs = 1'b0;
        tick();
        tick();
        check_output("t3_cpu_again", 32'(bus.ram_addr), 32'h0200);
        tick();
        tick();
        bus.cpu_ram_cs = 1'b0;
        bus.ram_ok     = 1'b0;
        tick();

        // 4: held VRAM chip select gets one grant only
        $display("[TB] test 4: held cpu_vram_cs");
        bus.cpu_vram_cs = 1'b1;
        bus.cpu_addr    = 15'h0300;
        bus.cpu_dout    = 16'hcafe;
        bus.UDSWn       = 1'b0;
        bus.LDSWn       = 1'b1;
        tick();
        check_output("t4_vram_cs", 32'(bus.vram_cs), 1);
        check_output("t4_ram_cs",  32'(bus.ram_cs),  0);
        check_output("t4_dsn",     32'(bus.ram_dsn), 1);
        check_output("t4_we",      32'(bus.ram_we),  1);
        check_output("t4_din",     32'(bus.ram_din), 32'hcafe);
        bus.ram_ok = 1'b1;
        tick();
        tick();
        check_output("t4_cpu_ok",  32'(bus.cpu_ok),  1);
        bus.ram_ok   = 1'b0;
        bus.cpu_addr = 15'h0301;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("t4_no_regnt", 32'({bus.vram_cs, bus.ram_cs}), 0);
        end
        bus.cpu_vram_cs = 1'b0;
        tick();
        check_output("t4_ok_clr",  32'(bus.cpu_ok),  0);
        check_output("t4_low",     32'(bus.vram_cs), 0);
        bus.cpu_vram_cs = 1'b1;
        bus.cpu_ram_cs  = 1'b1;
        bus.UDSWn       = 1'b1;
        tick();
        check_output("t4_both_ram",  32'(bus.ram_cs),  1);
        check_output("t4_both_vram", 32'(bus.vram_cs), 0);
        bus.ram_ok = 1'b1;
        tick();
        tick();
        check_output("t4_ok2",     32'(bus.cpu_ok),  1);
        bus.cpu_vram_cs = 1'b0;
        bus.cpu_ram_cs  = 1'b0;
        bus.ram_ok      = 1'b0;
        tick();
        tick();

        // 5: ram_ok never arrives
        $display("[TB] test 5: timeout");
        bus.cpu_ram_cs = 1'b1;
        bus.cpu_addr   = 15'h0400;
        tick();
        check_output("t5_ram_cs", 32'(bus.ram_cs), 1);
        n = 0;
        while (n <= 300 && !bus.cpu_ok) begin
            tick();
            n++;
        end
        check_output("t5_cycles",   32'(n),            255);
        check_output("t5_cpu_data", 32'(bus.cpu_data), 32'hffff);
        check_output("t5_timeout",  32'(bus.timeout),  1);
        check_output("t5_cs_drop",  32'(bus.ram_cs),   0);
        bus.cpu_ram_cs = 1'b0;
        tick();
        tick();
        check_output("t5_sticky",   32'(bus.timeout),  1);

        // 6: reset in the middle of a grant
        $display("[TB] test 6: reset mid-grant");
        bus.cpu_vram_cs = 1'b1;
        tick();
        check_output("t6_vram_cs", 32'(bus.vram_cs), 1);
        rst = 1'b1;
        tick();
        check_output("t6_cs",      32'({bus.ram_cs, bus.vram_cs}), 0);
        check_output("t6_oks",     32'({bus.cpu_ok, bus.mcu_ok}),  0);
        check_output("t6_dsn",     32'(bus.ram_dsn), 3);
        check_output("t6_timeout", 32'(bus.timeout), 0);
        rst          = 1'b0;
        bus.mcu_cs   = 1'b1;
        bus.mcu_addr = 16'h0001;
        tick();
        check_output("t6_cpu_wins", 32'(bus.vram_cs), 1);
        check_output("t6_addr",     32'(bus.ram_addr), 32'h0400);
        bus.cpu_vram_cs = 1'b0;
        bus.mcu_cs      = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
